// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS,
    APB_RESP
  } apb_state_e;

endpackage

// File: rtl/apb_intf.sv
// APB3 bus bundle; the initiator uses the master view, register blocks the slave view.
interface apb_intf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_initiator.sv
// APB3 requester: converts a valid/ready request into one APB transfer and
// returns the result on a valid/ready response channel. One transfer in flight.
module apb_initiator
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  apb_intf.master           apb_intf
);

  // Counter wide enough to hold TIMEOUT; a disabled timeout still needs one bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  apb_state_e        state_reg;
  logic              psel_reg;
  logic              penable_reg;
  logic              pwrite_reg;
  logic [ADDR_W-1:0] paddr_reg;
  logic [DATA_W-1:0] pwdata_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic              rsp_err_reg;
  logic              rsp_timeout_reg;
  logic [CNT_W-1:0]  tmo_cnt_reg;

  // Requests are only taken in IDLE; depends on state alone so req_valid never loops back.
  assign req_ready = (state_reg == APB_IDLE);

  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_timeout = rsp_timeout_reg;

  assign apb_intf.psel    = psel_reg;
  assign apb_intf.penable = penable_reg;
  assign apb_intf.pwrite  = pwrite_reg;
  assign apb_intf.paddr   = paddr_reg;
  assign apb_intf.pwdata  = pwdata_reg;

  // Transfer sequencer: request capture, APB phases, wait/timeout counting and response hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= APB_IDLE;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      tmo_cnt_reg     <= '0;
    end else begin
      case (state_reg)
        APB_IDLE: begin
          if (req_valid) begin
            // Address/data/direction are latched here and held until the next request.
            state_reg   <= APB_SETUP;
            psel_reg    <= 1'b1;
            penable_reg <= 1'b0;
            pwrite_reg  <= req_write;
            paddr_reg   <= req_addr;
            pwdata_reg  <= req_wdata;
            tmo_cnt_reg <= '0;
          end
        end

        APB_SETUP: begin
          state_reg   <= APB_ACCESS;
          penable_reg <= 1'b1;
        end

        APB_ACCESS: begin
          if (apb_intf.pready) begin
            // A completing slave beats the timeout when both happen together.
            state_reg       <= APB_RESP;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_rdata_reg   <= pwrite_reg ? '0 : apb_intf.prdata;
            rsp_err_reg     <= apb_intf.pslverr;
            rsp_timeout_reg <= 1'b0;
          end else if ((TIMEOUT != 0) && (tmo_cnt_reg == CNT_LAST)) begin
            state_reg       <= APB_RESP;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b1;
            rsp_timeout_reg <= 1'b1;
          end else if (tmo_cnt_reg != CNT_SAT) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end

        APB_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= APB_IDLE;
          end
        end

        default: begin
          state_reg <= APB_IDLE;
        end
      endcase
    end
  end

endmodule
